// File: rtl/abs_clip_pwm.sv
// abs_clip_pwm: rectify and clip a signed sample stream, then use it to set the duty of a fixed-period PWM clock
module abs_clip_pwm #(
  parameter int DATA_W = 16,
  parameter int PERIOD = 1000,
  parameter int LOWER  = 1638,
  parameter int UPPER  = 29491
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-2:0] y,
  output logic [DATA_W-2:0] x,
  output logic              clk_out,
  output logic              period_start
);
  localparam int CW = $clog2(PERIOD + 1);
  localparam int PW = DATA_W - 1 + CW;
  localparam logic [DATA_W-2:0] LO  = (DATA_W-1)'(LOWER);
  localparam logic [DATA_W-2:0] HI  = (DATA_W-1)'(UPPER);
  localparam logic [DATA_W-2:0] MAX = {(DATA_W-1){1'b1}};
  localparam logic [CW-1:0]     LAST = CW'(PERIOD - 1);
  localparam logic [PW-1:0]     PER  = PW'(PERIOD);
  logic [DATA_W-1:0] neg;
  logic [DATA_W-2:0] y_q, y_d, x_q, x_d;
  logic [CW-1:0]     cnt_q, cnt_d, hi_reg_q, hi_reg_d, hi;
  logic              clk_out_q, clk_out_d, period_start_q, period_start_d;
  // Next-state: rectify with saturation, clip, free-running counter, per-period duty latch, PWM compare
  always_comb begin
    neg            = -in_data;
    y_d            = !in_valid ? y_q :
                     !in_data[DATA_W-1] ? in_data[DATA_W-2:0] :
                     neg[DATA_W-1] ? MAX : neg[DATA_W-2:0];
    x_d            = (y_q < LO) ? LO : (y_q > HI) ? HI : y_q;
    hi             = CW'((PW'(x_q) * PER) >> (DATA_W - 1));
    cnt_d          = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    hi_reg_d       = (cnt_q == LAST) ? hi : hi_reg_q;
    clk_out_d      = cnt_q < hi_reg_q;
    period_start_d = cnt_q == '0;
  end
  // State registers, all cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q            <= '0;
      x_q            <= '0;
      cnt_q          <= '0;
      hi_reg_q       <= '0;
      clk_out_q      <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      y_q            <= y_d;
      x_q            <= x_d;
      cnt_q          <= cnt_d;
      hi_reg_q       <= hi_reg_d;
      clk_out_q      <= clk_out_d;
      period_start_q <= period_start_d;
    end
  end
  assign y            = y_q;
  assign x            = x_q;
  assign clk_out      = clk_out_q;
  assign period_start = period_start_q;
endmodule

// File: tb/tb_abs_clip_pwm.sv
// tb_abs_clip_pwm: scoreboard of expected per-period high times, measured between period_start pulses
module tb_abs_clip_pwm;
  localparam int DATA_W = 16;
  localparam int PERIOD = 1000;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic [DATA_W-2:0] y, x;
  logic              clk_out, period_start;
  int checks = 0;
  int failures = 0;
  int sb[$];
  abs_clip_pwm #(.DATA_W(DATA_W), .PERIOD(PERIOD), .LOWER(1638), .UPPER(29491)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .y(y), .x(x), .clk_out(clk_out), .period_start(period_start)
  );
  always #5 clk = ~clk;
  // Wait for the next period_start, then count high cycles over one period; optionally change in_data at offset chg_at
  task automatic measure(output int h, input int chg_at, input logic [DATA_W-1:0] chg_data);
    bit found = 1'b0;
    for (int i = 0; i < 2 * PERIOD && !found; i++) begin
      @(negedge clk);
      found = period_start;
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL period_start timeout: no pulse within %0d cycles", 2 * PERIOD);
      h = -1;
      return;
    end
    h = int'(clk_out);
    for (int i = 1; i < PERIOD; i++) begin
      @(negedge clk);
      if (i == chg_at) in_data = chg_data;
      h += int'(clk_out);
    end
  endtask
  task automatic test_reset();
    int h, e;
    rst_n = 1'b0;
    in_data = 16'h4000;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks += 4;
    if (y !== 15'd0) begin failures++; $display("FAIL reset y: got %0d want 0", y); end
    if (x !== 15'd0) begin failures++; $display("FAIL reset x: got %0d want 0", x); end
    if (clk_out !== 1'b0) begin failures++; $display("FAIL reset clk_out: got %b want 0", clk_out); end
    if (period_start !== 1'b0) begin failures++; $display("FAIL reset period_start: got %b want 0", period_start); end
    rst_n = 1'b1;
    sb.push_back(0);
    sb.push_back(500);
    sb.push_back(500);
    while (sb.size() > 0) begin
      measure(h, -1, '0);
      e = sb.pop_front();
      checks++;
      if (h !== e) begin failures++; $display("FAIL half_scale high_time: got %0d want %0d", h, e); end
    end
    checks += 2;
    if (y !== 15'd16384) begin failures++; $display("FAIL half_scale y: got %0d want 16384", y); end
    if (x !== 15'd16384) begin failures++; $display("FAIL half_scale x: got %0d want 16384", x); end
  endtask
  task automatic test_rectify();
    int h, e;
    in_data = 16'hC000;
    sb.push_back(500);
    sb.push_back(500);
    while (sb.size() > 0) begin
      measure(h, -1, '0);
      e = sb.pop_front();
      checks++;
      if (h !== e) begin failures++; $display("FAIL rectify high_time: got %0d want %0d", h, e); end
    end
    checks++;
    if (y !== 15'd16384) begin failures++; $display("FAIL rectify y: got %0d want 16384", y); end
  endtask
  task automatic test_lower_clip();
    int h, e;
    in_data = 16'h0000;
    sb.push_back(500);
    sb.push_back(49);
    sb.push_back(49);
    while (sb.size() > 0) begin
      measure(h, -1, '0);
      e = sb.pop_front();
      checks++;
      if (h !== e) begin failures++; $display("FAIL lower_clip high_time: got %0d want %0d", h, e); end
    end
    checks += 2;
    if (y !== 15'd0) begin failures++; $display("FAIL lower_clip y: got %0d want 0", y); end
    if (x !== 15'd1638) begin failures++; $display("FAIL lower_clip x: got %0d want 1638", x); end
  endtask
  task automatic test_upper_clip();
    int h, e;
    in_data = 16'h7FFF;
    sb.push_back(49);
    sb.push_back(899);
    while (sb.size() > 0) begin
      measure(h, -1, '0);
      e = sb.pop_front();
      checks++;
      if (h !== e) begin failures++; $display("FAIL upper_clip high_time: got %0d want %0d", h, e); end
    end
    checks += 2;
    if (y !== 15'd32767) begin failures++; $display("FAIL upper_clip y: got %0d want 32767", y); end
    if (x !== 15'd29491) begin failures++; $display("FAIL upper_clip x: got %0d want 29491", x); end
  endtask
  task automatic test_saturate();
    int h, e;
    in_data = 16'h8000;
    sb.push_back(899);
    sb.push_back(899);
    while (sb.size() > 0) begin
      measure(h, -1, '0);
      e = sb.pop_front();
      checks++;
      if (h !== e) begin failures++; $display("FAIL saturate high_time: got %0d want %0d", h, e); end
    end
    checks += 2;
    if (y !== 15'd32767) begin failures++; $display("FAIL saturate y: got %0d want 32767", y); end
    if (x !== 15'd29491) begin failures++; $display("FAIL saturate x: got %0d want 29491", x); end
  endtask
  task automatic test_back_to_back();
    int h, e;
    in_data = 16'h4000;
    sb.push_back(899);
    sb.push_back(500);
    while (sb.size() > 0) begin
      measure(h, -1, '0);
      e = sb.pop_front();
      checks++;
      if (h !== e) begin failures++; $display("FAIL b2b_setup high_time: got %0d want %0d", h, e); end
    end
    sb.push_back(500);
    measure(h, 300, 16'h2000);
    e = sb.pop_front();
    checks++;
    if (h !== e) begin failures++; $display("FAIL mid_change current high_time: got %0d want %0d", h, e); end
    sb.push_back(250);
    measure(h, -1, '0);
    e = sb.pop_front();
    checks++;
    if (h !== e) begin failures++; $display("FAIL mid_change next high_time: got %0d want %0d", h, e); end
    in_valid = 1'b0;
    in_data = 16'h7FFF;
    sb.push_back(250);
    sb.push_back(250);
    sb.push_back(250);
    while (sb.size() > 0) begin
      measure(h, -1, '0);
      e = sb.pop_front();
      checks++;
      if (h !== e) begin failures++; $display("FAIL hold high_time: got %0d want %0d", h, e); end
    end
    checks++;
    if (y !== 15'd8192) begin failures++; $display("FAIL hold y: got %0d want 8192", y); end
  endtask
  task automatic test_async_reset();
    int h, e;
    bit found = 1'b0;
    in_valid = 1'b1;
    in_data = 16'h4000;
    sb.push_back(250);
    sb.push_back(500);
    while (sb.size() > 0) begin
      measure(h, -1, '0);
      e = sb.pop_front();
      checks++;
      if (h !== e) begin failures++; $display("FAIL pre_reset high_time: got %0d want %0d", h, e); end
    end
    for (int i = 0; i < 2 * PERIOD && !found; i++) begin
      @(negedge clk);
      found = period_start;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL async_reset sync: no period_start within %0d cycles", 2 * PERIOD); end
    repeat (200) @(negedge clk);
    checks++;
    if (clk_out !== 1'b1) begin failures++; $display("FAIL async_reset pre clk_out: got %b want 1", clk_out); end
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (clk_out !== 1'b0) begin failures++; $display("FAIL async_reset clk_out: got %b want 0", clk_out); end
    if (y !== 15'd0) begin failures++; $display("FAIL async_reset y: got %0d want 0", y); end
    if (x !== 15'd0) begin failures++; $display("FAIL async_reset x: got %0d want 0", x); end
    if (period_start !== 1'b0) begin failures++; $display("FAIL async_reset period_start: got %b want 0", period_start); end
    in_data = 16'h8000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(0);
    sb.push_back(899);
    while (sb.size() > 0) begin
      measure(h, -1, '0);
      e = sb.pop_front();
      checks++;
      if (h !== e) begin failures++; $display("FAIL post_reset high_time: got %0d want %0d", h, e); end
    end
  endtask
  initial begin
    test_reset();
    test_rectify();
    test_lower_clip();
    test_upper_clip();
    test_saturate();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
